// File: rtl/rf_write_scheduler.sv
// Buffers result-bus writes per producer and round-robin drains up to NUM_WPORTS
// FIFO heads per cycle onto registered register-file write ports.
module rf_write_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_WPORTS = 3,
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 6,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         IN_flush,
    input  logic [NUM_REQ-1:0]           IN_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    IN_addr,
    input  logic [NUM_REQ*WIDTH-1:0]     IN_data,
    output logic [NUM_REQ-1:0]           OUT_ready,
    output logic [NUM_WPORTS-1:0]        OUT_wen,
    output logic [NUM_WPORTS*ADDR_W-1:0] OUT_waddr,
    output logic [NUM_WPORTS*WIDTH-1:0]  OUT_wdata,
    output logic                         OUT_busy,
    output logic [15:0]                  OUT_oversub
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ADDR_W-1:0] mem_addr [NUM_REQ][BUF_DEPTH];
    logic [WIDTH-1:0]  mem_data [NUM_REQ][BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr   [NUM_REQ];
    logic [PTR_W-1:0]  wr_ptr   [NUM_REQ];
    logic [CNT_W-1:0]  count    [NUM_REQ];
    logic [CNT_W-1:0]  cnt_next [NUM_REQ];
    logic [RR_W-1:0]   rr;
    logic [RR_W-1:0]   rr_next;

    logic [NUM_REQ-1:0]    nonempty;
    logic [NUM_REQ-1:0]    enq;
    logic [NUM_REQ-1:0]    deq;
    logic [NUM_WPORTS-1:0] port_gnt;
    logic [RR_W-1:0]       port_src  [NUM_WPORTS];
    logic [ADDR_W-1:0]     port_addr [NUM_WPORTS];
    logic [WIDTH-1:0]      port_data [NUM_WPORTS];
    logic                  oversub_cyc;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            nonempty[i] = (count[i] != '0);
            // Address 0 is a handshake-only write: accepted but never stored.
            enq[i] = IN_valid[i] && OUT_ready[i] && !IN_flush &&
                     (IN_addr[i*ADDR_W +: ADDR_W] != '0);
        end
    end

    assign OUT_busy    = |nonempty;
    assign oversub_cyc = $countones(nonempty) > NUM_WPORTS;

    always_comb begin
        int unsigned n;
        int unsigned idx;
        n        = 0;
        idx      = 0;
        port_gnt = '0;
        deq      = '0;
        rr_next  = rr;
        for (int unsigned k = 0; k < NUM_WPORTS; k++) begin
            port_src[k] = '0;
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            idx = int'(rr) + j;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (nonempty[idx] && (n < NUM_WPORTS)) begin
                port_gnt[n] = 1'b1;
                port_src[n] = RR_W'(idx);
                deq[idx]    = 1'b1;
                rr_next     = RR_W'((idx + 1) % NUM_REQ);
                n           = n + 1;
            end
        end
        for (int unsigned k = 0; k < NUM_WPORTS; k++) begin
            port_addr[k] = mem_addr[port_src[k]][rd_ptr[port_src[k]]];
            port_data[k] = mem_data[port_src[k]][rd_ptr[port_src[k]]];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_next[i] = count[i] + CNT_W'(enq[i]) - CNT_W'(deq[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rst_n && enq[i]) begin
                mem_addr[i][wr_ptr[i]] <= IN_addr[i*ADDR_W +: ADDR_W];
                mem_data[i][wr_ptr[i]] <= IN_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr          <= '0;
            OUT_ready   <= '0;
            OUT_wen     <= '0;
            OUT_waddr   <= '0;
            OUT_wdata   <= '0;
            OUT_oversub <= '0;
        end else begin
            if (oversub_cyc && (OUT_oversub != '1)) OUT_oversub <= OUT_oversub + 16'd1;
            if (IN_flush) begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    rd_ptr[i] <= '0;
                    wr_ptr[i] <= '0;
                    count[i]  <= '0;
                end
                OUT_ready <= '1;
                OUT_wen   <= '0;
            end else begin
                rr <= rr_next;
                for (int unsigned k = 0; k < NUM_WPORTS; k++) begin
                    OUT_wen[k] <= port_gnt[k];
                    if (port_gnt[k]) begin
                        OUT_waddr[k*ADDR_W +: ADDR_W] <= port_addr[k];
                        OUT_wdata[k*WIDTH +: WIDTH]   <= port_data[k];
                    end
                end
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (enq[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                    if (deq[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                    count[i]     <= cnt_next[i];
                    OUT_ready[i] <= (cnt_next[i] < CNT_W'(BUF_DEPTH));
                end
            end
        end
    end

    // The renamer guarantees distinct destinations per cycle; this only flags a violation.
    always_ff @(posedge clk) begin
        if (rst_n && !IN_flush) begin
            for (int unsigned a = 0; a < NUM_WPORTS; a++) begin
                for (int unsigned b = a + 1; b < NUM_WPORTS; b++) begin
                    if (port_gnt[a] && port_gnt[b]) begin
                        assert (port_addr[a] != port_addr[b]);
                    end
                end
            end
        end
    end

endmodule
